lattice_store: RTL and testbench
================================

LATTICE_STORE -- requirements
Module: lattice_store

Interface
REQ-001 Parameter HPIXELS, default 205, lattice width in cells.
REQ-002 Parameter VPIXELS, default 154, lattice height in cells.
REQ-003 Parameter RW_LATENCY, default 3, request-to-read-data latency in cycles.
REQ-004 Port clk_in  input  1  sole clock; all logic on rising edge.
REQ-005 Port rst_n_in  input  1  asynchronous, active-low reset.
REQ-006 Port addr_in  input  9 x BRAM_SIZE  per-direction cell address; lane 0 (rest) ignored, lanes 1..8 address banks 0..7.
REQ-007 Port wdata_in  input  8 x 9  per-direction write data, lane k to bank k.
REQ-008 Port req_valid_in  input  1  access request this cycle.
REQ-009 Port we_in  input  1  1 = write, 0 = read; sampled only with req_valid_in.
REQ-010 Port init_in  input  1  start fill pulse.
REQ-011 Port init_value_in  input  8 x 9  per-direction fill value, sampled on init_in.
REQ-012 Port rdata_out  output  8 x 9  read data, lane k from bank k.
REQ-013 Port rvalid_out  output  1  rdata_out valid this cycle.
REQ-014 Port busy_out  output  1  fill in progress.
REQ-015 Port init_done_out  output  1  one-cycle pulse at fill completion.
REQ-016 Port err_out  output  1  sticky error flag.

Function
REQ-017 The block SHALL hold 8 independent banks, each BRAM_DEPTH = HPIXELS*VPIXELS words x 9 bits, one operation per bank per cycle.
REQ-018 A read request at cycle N SHALL produce rdata_out with rvalid_out=1 at exactly N+RW_LATENCY; rvalid_out=0 otherwise.
REQ-019 A write request at cycle N SHALL update all 8 banks at their lane addresses at N; a read of the same address at N+1 or later SHALL return the new value.
REQ-020 Back-to-back requests on every cycle SHALL be accepted with no bubbles; read data order SHALL equal request order.
REQ-021 Any lane address >= BRAM_DEPTH SHALL suppress that lane's write, return 0 on that lane for a read, and set err_out; other lanes proceed normally.
REQ-022 States: IDLE, FILL. IDLE -> FILL on init_in; FILL sweeps address 0..BRAM_DEPTH-1, one address per cycle, writing init_value to all banks; FILL -> IDLE after address BRAM_DEPTH-1.
REQ-023 busy_out SHALL be 1 for exactly BRAM_DEPTH cycles starting the cycle after init_in; init_done_out SHALL pulse the cycle busy_out falls.
REQ-024 Requests during FILL SHALL be dropped (no write, no rvalid_out) and SHALL set err_out.
REQ-025 init_in during FILL SHALL be ignored; init_in with req_valid_in in IDLE: init wins, request dropped, err_out set.
REQ-026 Reads in flight when FILL starts SHALL still complete with their pre-fill data.
REQ-027 err_out SHALL clear only on reset.

Reset
REQ-028 On rst_n_in low, asynchronously: state IDLE, rvalid_out 0, busy_out 0, init_done_out 0, err_out 0, rdata_out 0, fill counter 0, latency pipeline valids 0.
REQ-029 Reset mid-FILL SHALL abort the sweep with no init_done_out; memory contents are then undefined until the next fill.
REQ-030 Bank memory contents SHALL NOT be reset.

Structure
REQ-031 Package lbm_pkg SHALL hold HPIXELS, VPIXELS, BRAM_DEPTH, BRAM_SIZE, RW_LATENCY, Q=9 directions, and cell data width 9.
REQ-032 One sub-module lattice_bank SHALL implement a single-port 9-bit bank with registered output, instantiated 8 times; the remaining latency SHALL be an output register stage in lattice_store.

Verification
REQ-033 Write addr lanes 1..8 = 10..17, data k*3 -> read same addresses next cycle gives rdata lane k = k*3 exactly 3 cycles later, rvalid 1 one cycle.
REQ-034 Write then read 100 consecutive addresses at full rate -> 100 rvalid cycles in order, no gaps, all data matching.
REQ-035 init_in with init_value lane k = 0x100+k -> busy 31570 cycles, init_done one pulse, random reads return 0x100+k.
REQ-036 Read at address 31570 on lane 3 -> lane 3 returns 0, others correct, err_out 1 and stays 1.
REQ-037 Request during FILL -> no rvalid, no write, err_out 1; second init_in during FILL has no effect on busy duration.
REQ-038 Assert rst_n_in low at fill cycle 500 -> all outputs 0 immediately, no init_done_out, IDLE after release.

Source files
------------

// File: rtl/lbm_pkg.sv
// lbm_pkg: shared geometry, latency and type definitions for the lattice store.
package lbm_pkg;

   localparam int HPIXELS    = 205;
   localparam int VPIXELS    = 154;
   localparam int BRAM_DEPTH = HPIXELS * VPIXELS;
   localparam int BRAM_SIZE  = $clog2(BRAM_DEPTH);
   localparam int RW_LATENCY = 3;
   localparam int Q          = 9;           // lattice directions, lane 0 is the rest direction
   localparam int NBANK      = Q - 1;       // one bank per moving direction
   localparam int CELL_W     = 9;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } fill_state_e;

endpackage

// File: rtl/lattice_bank.sv
// lattice_bank: one single-port 9-bit bank with a registered read port.
module lattice_bank #(
   parameter int DEPTH = lbm_pkg::BRAM_DEPTH,
   parameter int AW    = lbm_pkg::BRAM_SIZE
) (
   input  logic                      clk_in,
   input  logic                      en_in,
   input  logic                      we_in,
   input  logic [AW-1:0]             addr_in,
   input  logic [lbm_pkg::CELL_W-1:0] wdata_in,
   output logic [lbm_pkg::CELL_W-1:0] rdata_out
);

   import lbm_pkg::*;

   logic [CELL_W-1:0] mem [DEPTH];
   logic [CELL_W-1:0] rdata_q, rdata_d;

   // Next read data: load on a read, otherwise hold
   always_comb begin
      rdata_d = rdata_q;
      if (en_in && !we_in) begin
         rdata_d = mem[addr_in];
      end
   end

   // Storage array and read register
   // NOTE: no reset here -- a reset term would stop the array mapping onto block RAM,
   // and the store's own pipeline masks the read register until it holds real data.
   always_ff @(posedge clk_in) begin
      if (en_in && we_in) begin
         mem[addr_in] <= wdata_in;
      end
      rdata_q <= rdata_d;
   end

   assign rdata_out = rdata_q;

endmodule

// File: rtl/lattice_store.sv
// lattice_store: eight 9-bit lattice banks behind a common request port, a
// fixed-latency read pipeline, and a fill engine that sweeps every cell to a
// per-direction initial value.
module lattice_store #(
   parameter int HPIXELS    = lbm_pkg::HPIXELS,
   parameter int VPIXELS    = lbm_pkg::VPIXELS,
   parameter int RW_LATENCY = lbm_pkg::RW_LATENCY   // must be >= 2
) (
   input  logic                                          clk_in,
   input  logic                                          rst_n_in,
   input  logic [lbm_pkg::Q*$clog2(HPIXELS*VPIXELS)-1:0] addr_in,
   input  logic [lbm_pkg::NBANK*lbm_pkg::CELL_W-1:0]     wdata_in,
   input  logic                                          req_valid_in,
   input  logic                                          we_in,
   input  logic                                          init_in,
   input  logic [lbm_pkg::NBANK*lbm_pkg::CELL_W-1:0]     init_value_in,
   output logic [lbm_pkg::NBANK*lbm_pkg::CELL_W-1:0]     rdata_out,
   output logic                                          rvalid_out,
   output logic                                          busy_out,
   output logic                                          init_done_out,
   output logic                                          err_out
);

   import lbm_pkg::*;

   localparam int              DEPTH   = HPIXELS * VPIXELS;
   localparam int              AW      = $clog2(DEPTH);
   localparam int              DW      = NBANK * CELL_W;
   localparam int              LAST    = DEPTH - 1;
   localparam logic [AW-1:0]   LAST_C  = LAST[AW-1:0];
   localparam logic [AW:0]     DEPTH_C = DEPTH[AW:0];

   fill_state_e                   state_q, state_d;
   logic [AW-1:0]                 fill_cnt_q, fill_cnt_d;
   logic [DW-1:0]                 init_val_q, init_val_d;
   logic                          busy_q, busy_d;
   logic                          done_q, done_d;
   logic                          err_q, err_d;
   logic                          req_take;
   logic                          rd_take;

   logic [AW-1:0]                 lane_addr [NBANK];
   logic [NBANK-1:0]              lane_bad;

   logic [NBANK-1:0]              bank_en, bank_we;
   logic [AW-1:0]                 bank_addr  [NBANK];
   logic [CELL_W-1:0]             bank_wdata [NBANK];
   logic [CELL_W-1:0]             bank_rdata [NBANK];

   logic [RW_LATENCY-1:0]         rv_q, rv_d;
   logic [NBANK-1:0]              bad_q, bad_d;
   logic [RW_LATENCY-2:0][DW-1:0] dat_q, dat_d;

   // The rest-direction address lane has no bank behind it
   logic unused_lane0;
   assign unused_lane0 = ^addr_in[AW-1:0];

   // Split the flat address bus into bank lanes and flag cells beyond the lattice
   always_comb begin
      for (int k = 0; k < NBANK; k++) begin
         lane_addr[k] = addr_in[(k+1)*AW +: AW];
         lane_bad[k]  = ({1'b0, lane_addr[k]} >= DEPTH_C);
      end
   end

   // FSM next state: accept requests in IDLE, sweep the lattice in FILL
   // NOTE: every output of this block gets a default first, so no path can leave
   // one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      init_val_d = init_val_q;
      done_d     = 1'b0;
      err_d      = err_q;
      req_take   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (init_in) begin
               // a fill start beats a request arriving in the same cycle
               state_d    = ST_FILL;
               fill_cnt_d = '0;
               init_val_d = init_value_in;
               if (req_valid_in) err_d = 1'b1;
            end else if (req_valid_in) begin
               req_take = 1'b1;
               if (|lane_bad) err_d = 1'b1;
            end
         end
         ST_FILL: begin
            if (req_valid_in) err_d = 1'b1;
            fill_cnt_d = fill_cnt_q + AW'(1);
            if (fill_cnt_q == LAST_C) begin
               state_d    = ST_IDLE;
               fill_cnt_d = '0;
               done_d     = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d  = (state_d == ST_FILL);
      rd_take = req_take && !we_in;
   end

   // FSM state and its registered status outputs
   // NOTE: sequential state uses non-blocking assignment so every flop samples
   // the values from before this edge, independent of block evaluation order.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= ST_IDLE;
         fill_cnt_q <= '0;
         init_val_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         fill_cnt_q <= fill_cnt_d;
         init_val_q <= init_val_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   // Bank port steering: the fill sweep owns every bank while it runs
   always_comb begin
      for (int k = 0; k < NBANK; k++) begin
         if (state_q == ST_FILL) begin
            bank_en[k]    = 1'b1;
            bank_we[k]    = 1'b1;
            bank_addr[k]  = fill_cnt_q;
            bank_wdata[k] = init_val_q[k*CELL_W +: CELL_W];
         end else begin
            bank_en[k]    = req_take && !lane_bad[k];
            bank_we[k]    = we_in;
            bank_addr[k]  = lane_addr[k];
            bank_wdata[k] = wdata_in[k*CELL_W +: CELL_W];
         end
      end
   end

   for (genvar k = 0; k < NBANK; k++) begin : g_bank
      lattice_bank #(
         .DEPTH (DEPTH),
         .AW    (AW)
      ) u_bank (
         .clk_in    (clk_in),
         .en_in     (bank_en[k]),
         .we_in     (bank_we[k]),
         .addr_in   (bank_addr[k]),
         .wdata_in  (bank_wdata[k]),
         .rdata_out (bank_rdata[k])
      );
   end

   // Read pipeline: bank register plus RW_LATENCY-1 output stages; lanes that
   // addressed a cell outside the lattice are forced to zero
   always_comb begin
      rv_d     = {rv_q[RW_LATENCY-2:0], rd_take};
      bad_d    = lane_bad;
      dat_d    = dat_q;
      dat_d[0] = '0;
      if (rv_q[0]) begin
         for (int k = 0; k < NBANK; k++) begin
            dat_d[0][k*CELL_W +: CELL_W] = bad_q[k] ? '0 : bank_rdata[k];
         end
      end
      for (int s = 1; s < RW_LATENCY - 1; s++) begin
         dat_d[s] = dat_q[s-1];
      end
   end

   // Read pipeline registers
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rv_q  <= '0;
         bad_q <= '0;
         dat_q <= '0;
      end else begin
         rv_q  <= rv_d;
         bad_q <= bad_d;
         dat_q <= dat_d;
      end
   end

   assign rdata_out     = dat_q[RW_LATENCY-2];
   assign rvalid_out    = rv_q[RW_LATENCY-1];
   assign busy_out      = busy_q;
   assign init_done_out = done_q;
   assign err_out       = err_q;

endmodule

// File: tb/tb_lattice_store.sv
// tb_lattice_store: table-driven directed vectors plus randomized traffic
// checked against a transaction-level model of the lattice store.
`timescale 1ns/1ps
module tb_lattice_store;

   import lbm_pkg::*;

   localparam int DEPTH = BRAM_DEPTH;
   localparam int AW    = BRAM_SIZE;
   localparam int DW    = NBANK * CELL_W;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [Q*AW-1:0] addr_in;
   logic [DW-1:0]   wdata_in, init_value_in, rdata_out;
   logic            req_valid_in, we_in, init_in;
   logic            rvalid_out, busy_out, init_done_out, err_out;

   // per-lane drive values, packed onto the flat buses below
   logic [AW-1:0]     d_addr  [Q];
   logic [CELL_W-1:0] d_wdata [NBANK];
   logic [CELL_W-1:0] d_init  [NBANK];

   // reference model state
   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } resp_t;

   logic [CELL_W-1:0] mem_m [NBANK][DEPTH];
   logic [CELL_W-1:0] m_initval [NBANK];
   resp_t             pend [$];
   bit                m_fill;
   int                m_fill_addr;
   logic              exp_busy, exp_done, exp_err;
   int                cyc;
   int                n_checks, n_pass;

   typedef struct {
      logic          req;
      logic          we;
      int            base;
      int            mul;
      logic          bad3;
      logic          exp_rv;
      logic [DW-1:0] exp_rd;
      logic          exp_err;
   } vec_t;

   vec_t vecs [11];

   always #5 clk = ~clk;

   always_comb begin
      addr_in       = '0;
      wdata_in      = '0;
      init_value_in = '0;
      for (int j = 0; j < Q; j++) addr_in[j*AW +: AW] = d_addr[j];
      for (int k = 0; k < NBANK; k++) begin
         wdata_in[k*CELL_W +: CELL_W]      = d_wdata[k];
         init_value_in[k*CELL_W +: CELL_W] = d_init[k];
      end
   end

   lattice_store #(
      .HPIXELS    (HPIXELS),
      .VPIXELS    (VPIXELS),
      .RW_LATENCY (RW_LATENCY)
   ) dut (
      .clk_in        (clk),
      .rst_n_in      (rst_n),
      .addr_in       (addr_in),
      .wdata_in      (wdata_in),
      .req_valid_in  (req_valid_in),
      .we_in         (we_in),
      .init_in       (init_in),
      .init_value_in (init_value_in),
      .rdata_out     (rdata_out),
      .rvalid_out    (rvalid_out),
      .busy_out      (busy_out),
      .init_done_out (init_done_out),
      .err_out       (err_out)
   );

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
   endtask

   task automatic check_vec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic clear_drive();
      req_valid_in = 1'b0;
      we_in        = 1'b0;
      init_in      = 1'b0;
      for (int j = 0; j < Q; j++) d_addr[j] = '0;
      for (int k = 0; k < NBANK; k++) begin
         d_wdata[k] = '0;
         d_init[k]  = '0;
      end
   endtask

   // lanes 1..8 get consecutive cells from base; lane 0 carries junk
   task automatic set_lanes(input int base);
      d_addr[0] = AW'($urandom);
      for (int j = 1; j < Q; j++) d_addr[j] = AW'(base + j - 1);
   endtask

   // Apply the current inputs to the model: what the store does at this edge
   task automatic model_step();
      logic [DW-1:0] rd;
      resp_t         r;
      int            a;
      exp_done = 1'b0;
      if (m_fill) begin
         for (int b = 0; b < NBANK; b++) mem_m[b][m_fill_addr] = m_initval[b];
         if (req_valid_in) exp_err = 1'b1;
         m_fill_addr++;
         if (m_fill_addr == DEPTH) begin
            m_fill   = 1'b0;
            exp_done = 1'b1;
         end
      end else if (init_in) begin
         m_fill      = 1'b1;
         m_fill_addr = 0;
         for (int b = 0; b < NBANK; b++) m_initval[b] = d_init[b];
         if (req_valid_in) exp_err = 1'b1;
      end else if (req_valid_in) begin
         rd = '0;
         for (int b = 0; b < NBANK; b++) begin
            a = int'(d_addr[b+1]);
            if (a >= DEPTH) exp_err = 1'b1;
            else if (we_in) mem_m[b][a] = d_wdata[b];
            else rd[b*CELL_W +: CELL_W] = mem_m[b][a];
         end
         if (!we_in) begin
            r.due  = cyc + RW_LATENCY;
            r.data = rd;
            pend.push_back(r);
         end
      end
      exp_busy = m_fill;
   endtask

   // Compare this cycle's outputs with the model, then advance one clock
   task automatic tick();
      logic exp_rv;
      exp_rv = (pend.size() > 0) && (pend[0].due == cyc);
      check_bit("rvalid", rvalid_out, exp_rv);
      if (exp_rv) begin
         check_vec("rdata", rdata_out, pend[0].data);
         pend.delete(0);
      end
      check_bit("busy", busy_out, exp_busy);
      check_bit("init_done", init_done_out, exp_done);
      check_bit("err", err_out, exp_err);
      model_step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Assert reset between edges, confirm outputs drop at once, then release
   task automatic apply_reset();
      clear_drive();
      rst_n = 1'b0;
      #1;
      check_bit("rst_rvalid", rvalid_out, 1'b0);
      check_vec("rst_rdata", rdata_out, '0);
      check_bit("rst_busy", busy_out, 1'b0);
      check_bit("rst_init_done", init_done_out, 1'b0);
      check_bit("rst_err", err_out, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      pend.delete();
      m_fill      = 1'b0;
      m_fill_addr = 0;
      exp_busy    = 1'b0;
      exp_done    = 1'b0;
      exp_err     = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] e1, e2;
      int            busy_cnt, done_cnt, rv_cnt;

      n_checks = 0;
      n_pass   = 0;
      cyc      = 0;
      rst_n    = 1'b0;
      clear_drive();
      #1;
      apply_reset();

      // ---- directed table: write/read at lanes 10..17, then one bad lane ----
      for (int k = 0; k < NBANK; k++) e1[k*CELL_W +: CELL_W] = CELL_W'(k * 3);
      e2 = e1;
      e2[2*CELL_W +: CELL_W] = '0;   // addr lane 3 feeds bank 2
      vecs[0]  = '{1'b1, 1'b1, 10, 3, 1'b0, 1'b0, '0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 10, 0, 1'b0, 1'b0, '0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 0,  0, 1'b0, 1'b0, '0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 0,  0, 1'b0, 1'b0, '0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 0,  0, 1'b0, 1'b1, e1, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 0,  0, 1'b0, 1'b0, '0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 10, 0, 1'b1, 1'b0, '0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 0,  0, 1'b0, 1'b0, '0, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 0,  0, 1'b0, 1'b0, '0, 1'b1};
      vecs[9]  = '{1'b0, 1'b0, 0,  0, 1'b0, 1'b1, e2, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 0,  0, 1'b0, 1'b0, '0, 1'b1};
      for (int i = 0; i < 11; i++) begin
         clear_drive();
         req_valid_in = vecs[i].req;
         we_in        = vecs[i].we;
         set_lanes(vecs[i].base);
         if (vecs[i].bad3) d_addr[3] = AW'(DEPTH);
         for (int k = 0; k < NBANK; k++) d_wdata[k] = CELL_W'(k * vecs[i].mul);
         check_bit($sformatf("tbl%0d_rvalid", i), rvalid_out, vecs[i].exp_rv);
         if (vecs[i].exp_rv) check_vec($sformatf("tbl%0d_rdata", i), rdata_out, vecs[i].exp_rd);
         check_bit($sformatf("tbl%0d_err", i), err_out, vecs[i].exp_err);
         check_bit($sformatf("tbl%0d_busy", i), busy_out, 1'b0);
         @(posedge clk);
         #1;
         cyc++;
      end

      // ---- fill with a read in flight, a request and a second init mid-fill ----
      apply_reset();
      clear_drive();
      req_valid_in = 1'b1;
      we_in        = 1'b1;
      set_lanes(20);
      for (int k = 0; k < NBANK; k++) d_wdata[k] = CELL_W'($urandom);
      tick();
      we_in = 1'b0;
      tick();
      clear_drive();
      init_in = 1'b1;
      for (int k = 0; k < NBANK; k++) d_init[k] = CELL_W'(9'h100 + k);
      tick();
      busy_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < DEPTH + 10; i++) begin
         clear_drive();
         if (i == 1000) begin
            req_valid_in = 1'b1;
            set_lanes(int'($urandom_range(0, DEPTH - 9)));
         end
         if (i == 1001) begin
            req_valid_in = 1'b1;
            we_in        = 1'b1;
            for (int j = 0; j < Q; j++) d_addr[j] = AW'(5);
            for (int k = 0; k < NBANK; k++) d_wdata[k] = 9'h0AA;
         end
         if (i == 2000) begin
            init_in = 1'b1;
            for (int k = 0; k < NBANK; k++) d_init[k] = 9'h055;
         end
         if (busy_out) busy_cnt++;
         if (init_done_out) done_cnt++;
         tick();
      end
      check_int("fill_busy_cycles", busy_cnt, DEPTH);
      check_int("fill_done_pulses", done_cnt, 1);
      check_bit("fill_err_sticky", err_out, 1'b1);

      // ---- dropped write left address 5 at its fill value ----
      clear_drive();
      req_valid_in = 1'b1;
      for (int j = 0; j < Q; j++) d_addr[j] = AW'(5);
      tick();

      // ---- 100 writes then 100 reads at full rate ----
      for (int i = 0; i < 100; i++) begin
         clear_drive();
         req_valid_in = 1'b1;
         we_in        = 1'b1;
         for (int j = 0; j < Q; j++) d_addr[j] = AW'(300 + i);
         for (int k = 0; k < NBANK; k++) d_wdata[k] = CELL_W'($urandom);
         tick();
      end
      rv_cnt = 0;
      for (int i = 0; i < 105; i++) begin
         clear_drive();
         if (i < 100) begin
            req_valid_in = 1'b1;
            for (int j = 0; j < Q; j++) d_addr[j] = AW'(300 + i);
         end
         if (rvalid_out) rv_cnt++;
         tick();
      end
      check_int("burst_rvalid_count", rv_cnt, 100);

      // ---- random traffic, occasional out-of-range lanes ----
      for (int i = 0; i < 600; i++) begin
         clear_drive();
         if ($urandom_range(0, 3) != 0) begin
            req_valid_in = 1'b1;
            we_in        = 1'($urandom_range(0, 1));
            d_addr[0]    = AW'($urandom);
            for (int j = 1; j < Q; j++) begin
               if ($urandom_range(0, 39) == 0) d_addr[j] = AW'($urandom_range(DEPTH, (1 << AW) - 1));
               else d_addr[j] = AW'($urandom_range(0, DEPTH - 1));
            end
            for (int k = 0; k < NBANK; k++) d_wdata[k] = CELL_W'($urandom);
         end
         tick();
      end
      clear_drive();
      for (int i = 0; i < 5; i++) tick();
      check_int("random_drained", pend.size(), 0);

      // ---- reset at fill cycle 500 aborts the sweep ----
      apply_reset();
      clear_drive();
      init_in = 1'b1;
      for (int k = 0; k < NBANK; k++) d_init[k] = CELL_W'(k + 1);
      tick();
      clear_drive();
      for (int i = 0; i < 500; i++) tick();
      apply_reset();
      for (int i = 0; i < 4; i++) tick();
      req_valid_in = 1'b1;
      we_in        = 1'b1;
      set_lanes(40);
      for (int k = 0; k < NBANK; k++) d_wdata[k] = CELL_W'($urandom);
      tick();
      we_in = 1'b0;
      tick();
      clear_drive();
      for (int i = 0; i < 4; i++) tick();

      // ---- init and request together: init wins, request dropped ----
      req_valid_in = 1'b1;
      init_in      = 1'b1;
      set_lanes(40);
      for (int k = 0; k < NBANK; k++) d_init[k] = 9'h1FF;
      tick();
      clear_drive();
      for (int i = 0; i < 5; i++) tick();
      apply_reset();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
